// File: rtl/coin_pkg.sv
// Shared definitions for the coin input stage: event codes and default parameters.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_A    = 2'b01,
    COIN_B    = 2'b10
  } coin_code_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MAX_PULSE_DEF  = 64;

  // Debounce counter width covers the full legal DEB_CYCLES range (2..15).
  localparam int DEB_CNT_W = 4;

  function automatic coin_code_t coin_of(input logic take_a);
    coin_code_t code;
    if (take_a) begin
      code = COIN_A;
    end else begin
      code = COIN_B;
    end
    return code;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, debounce counter, stable level and rise pulse.
// With COIN_JAM_EN defined, a pulse-length counter flags a stuck-high sensor.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
`ifdef COIN_JAM_EN
  ,
  parameter int MAX_PULSE  = MAX_PULSE_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
`ifdef COIN_JAM_EN
  output logic stable,
  output logic jam_hit,
`endif
  output logic rise
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic [1:0]           sync_r;
  logic                 stable_r;
  logic [DEB_CNT_W-1:0] cnt_r;
  logic                 flip_s;

  // Two-stage synchronizer for the asynchronous sensor line.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // The level flips on the DEB_CYCLES-th consecutive disagreeing sample.
  assign flip_s = (sync_r[1] != stable_r) && (cnt_r == DEB_LAST);

  // Debounce counter and accepted level.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stable_r <= 1'b0;
      cnt_r    <= {DEB_CNT_W{1'b0}};
    end else if (sync_r[1] == stable_r) begin
      cnt_r    <= {DEB_CNT_W{1'b0}};
    end else if (flip_s) begin
      stable_r <= sync_r[1];
      cnt_r    <= {DEB_CNT_W{1'b0}};
    end else begin
      cnt_r    <= cnt_r + DEB_CNT_W'(1);
    end
  end

`ifdef COIN_JAM_EN
  localparam int            PW         = $clog2(MAX_PULSE + 1);
  localparam logic [PW-1:0] PULSE_MAX  = PW'(MAX_PULSE);
  localparam logic [PW-1:0] PULSE_LAST = PW'(MAX_PULSE - 1);

  logic [PW-1:0] pulse_cnt_r;
  logic          stuck_r;

  assign jam_hit = stable_r && (pulse_cnt_r == PULSE_LAST);
  assign stable  = stable_r;
  assign rise    = flip_s && sync_r[1] && !stuck_r;

  // Pulse-length counter saturates at MAX_PULSE; stuck holds until the level drops.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pulse_cnt_r <= {PW{1'b0}};
      stuck_r     <= 1'b0;
    end else if (!stable_r) begin
      pulse_cnt_r <= {PW{1'b0}};
      stuck_r     <= 1'b0;
    end else begin
      if (pulse_cnt_r != PULSE_MAX) begin
        pulse_cnt_r <= pulse_cnt_r + PW'(1);
      end
      if (jam_hit) begin
        stuck_r <= 1'b1;
      end
    end
  end
`else
  assign rise = flip_s && sync_r[1];
`endif

endmodule

// File: rtl/coin_front.sv
// Coin input stage: two debounced sensor channels, per-channel pending flags and an event FIFO.
// Optional jam detection is built when the COIN_JAM_EN macro is defined.
module coin_front
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MAX_PULSE  = MAX_PULSE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin_a_raw,
  input  logic                        coin_b_raw,
  input  logic                        coin_ready,
  output logic                        coin_valid,
  output logic [1:0]                  coin_code,
  output logic [$clog2(FIFO_DEPTH):0] coin_count,
  output logic                        overflow,
  output logic                        jam
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          rise_a_s, rise_b_s;
  logic          pend_a_r, pend_b_r;
  logic [1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic          pop_s, room_s, wr_a_s, wr_b_s, push_s, drop_s;
  coin_code_t    wr_code_s;

`ifdef COIN_JAM_EN
  logic stable_a_s, stable_b_s, hit_a_s, hit_b_s, jam_r;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .MAX_PULSE(MAX_PULSE)) u_deb_a (
    .clk(clk), .rst(rst), .raw(coin_a_raw),
    .stable(stable_a_s), .jam_hit(hit_a_s), .rise(rise_a_s)
  );
  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .MAX_PULSE(MAX_PULSE)) u_deb_b (
    .clk(clk), .rst(rst), .raw(coin_b_raw),
    .stable(stable_b_s), .jam_hit(hit_b_s), .rise(rise_b_s)
  );

  // Jam is raised by either channel and released only once both levels are low.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      jam_r <= 1'b0;
    end else if (!stable_a_s && !stable_b_s) begin
      jam_r <= 1'b0;
    end else if (hit_a_s || hit_b_s) begin
      jam_r <= 1'b1;
    end
  end

  assign jam = jam_r;
`else
  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk(clk), .rst(rst), .raw(coin_a_raw), .rise(rise_a_s)
  );
  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk(clk), .rst(rst), .raw(coin_b_raw), .rise(rise_b_s)
  );

  assign jam = 1'b0;
`endif

  // Write arbitration: A before B; a full FIFO still accepts when it is popped this cycle.
  always_comb begin
    pop_s  = (count_r != {CW{1'b0}}) && coin_ready;
    room_s = (count_r != FULL_CNT) || pop_s;
    wr_a_s = 1'b0;
    wr_b_s = 1'b0;
    if (room_s && pend_a_r) begin
      wr_a_s = 1'b1;
    end else if (room_s && pend_b_r) begin
      wr_b_s = 1'b1;
    end else begin
      wr_a_s = 1'b0;
      wr_b_s = 1'b0;
    end
    push_s    = wr_a_s || wr_b_s;
    wr_code_s = coin_of(wr_a_s);
    drop_s    = (rise_a_s && pend_a_r && !wr_a_s) || (rise_b_s && pend_b_r && !wr_b_s);
  end

  // Pending flags and sticky overflow; a flag freed this cycle can take a new event.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pend_a_r   <= 1'b0;
      pend_b_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      pend_a_r   <= (pend_a_r && !wr_a_s) || rise_a_s;
      pend_b_r   <= (pend_b_r && !wr_b_s) || rise_b_s;
      overflow_r <= overflow_r || drop_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= COIN_NONE;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wr_code_s;
    end
  end

  // Head of queue, forced to COIN_NONE while empty.
  always_comb begin
    if (count_r != {CW{1'b0}}) begin
      coin_code = mem_r[rd_ptr_r];
    end else begin
      coin_code = COIN_NONE;
    end
  end

  assign coin_valid = (count_r != {CW{1'b0}});
  assign coin_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_coin_front.sv
// Self-checking bench for coin_front: directed vector table, hand sequences, random vs. model.
module tb_coin_front;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b1;
  logic       rst = 1'b0;
  logic       a = 1'b0, b = 1'b0, rdy = 1'b0;
  logic       coin_valid, overflow, jam;
  logic [1:0] coin_code;
  logic [2:0] coin_count;

  coin_front #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .MAX_PULSE(64)) dut (
    .clk(clk), .rst(rst), .coin_a_raw(a), .coin_b_raw(b), .coin_ready(rdy),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_count(coin_count),
    .overflow(overflow), .jam(jam)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw sample history, accepted levels, pending flags, event queue.
  logic [19:0] ha = 20'd0, hb = 20'd0;
  bit sa = 1'b0, sb = 1'b0, pa = 1'b0, pb = 1'b0, movf = 1'b0;
  int q[$];

  // A level is accepted once the last DEB synchronized samples all disagree with it.
  function automatic bit settles(input logic [19:0] h, input bit st);
    logic [19:0] mask, win;
    mask = (20'd1 << DEB) - 20'd1;
    win  = (h >> 2) & mask;
    return st ? (win == 20'd0) : (win == mask);
  endfunction

  task automatic model_reset();
    ha = 20'd0; hb = 20'd0; sa = 1'b0; sb = 1'b0;
    pa = 1'b0; pb = 1'b0; movf = 1'b0; q.delete();
  endtask

  task automatic model_edge();
    bit ra, rb;
    ra = 1'b0; rb = 1'b0;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (q.size() < DEPTH) begin
      if (pa) begin q.push_back(1); pa = 1'b0; end
      else if (pb) begin q.push_back(2); pb = 1'b0; end
    end
    ha = {ha[18:0], a};
    hb = {hb[18:0], b};
    if (settles(ha, sa)) begin sa = !sa; ra = sa; end
    if (settles(hb, sb)) begin sb = !sb; rb = sb; end
    if (ra) begin if (pa) movf = 1'b1; else pa = 1'b1; end
    if (rb) begin if (pb) movf = 1'b1; else pb = 1'b1; end
  endtask

  // Advance n falling edges, stepping the model at each, and return just after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst) model_edge();
      @(posedge clk);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(coin_valid), 0);
    chk({tag, "_code"},  int'(coin_code),  0);
    chk({tag, "_count"}, int'(coin_count), 0);
    chk({tag, "_ovf"},   int'(overflow),   0);
    chk({tag, "_jam"},   int'(jam),        0);
  endtask

  typedef struct {
    bit ia; bit ib; bit ir; int n;
    bit ev; logic [1:0] ec; int en; bit eo;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int nv, pops, ra_left, rb_left;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 6,  1'b0, 2'b00, 0, 1'b0}; // accepted, not yet written
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1,  1'b1, 2'b01, 1, 1'b0}; // written at edge 7
    tbl[2] = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 2'b01, 1, 1'b0}; // release makes no event
    tbl[3] = '{1'b1, 1'b1, 1'b0, 7,  1'b1, 2'b01, 2, 1'b0}; // A written first
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 2'b01, 3, 1'b0}; // B one edge later
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1,  1'b1, 2'b01, 2, 1'b0}; // pop first A
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1,  1'b1, 2'b10, 1, 1'b0}; // pop second A
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 2'b00, 0, 1'b0}; // pop B
    tbl[8] = '{1'b0, 1'b0, 1'b1, 3,  1'b0, 2'b00, 0, 1'b0}; // ready ignored when empty

    repeat (2) @(posedge clk);
    chk_idle("reset");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      a = tbl[i].ia; b = tbl[i].ib; rdy = tbl[i].ir;
      step(tbl[i].n);
      chk($sformatf("vec%0d_valid", i), int'(coin_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d_code", i),  int'(coin_code),  int'(tbl[i].ec));
      chk($sformatf("vec%0d_count", i), int'(coin_count), tbl[i].en);
      chk($sformatf("vec%0d_ovf", i),   int'(overflow),   int'(tbl[i].eo));
    end

    // Clean 20-cycle pulse with ready high: exactly one cycle of valid.
    a = 1'b0; rdy = 1'b1; step(10);
    a = 1'b1; nv = 0;
    for (int i = 0; i < 26; i++) begin
      if (i == 20) a = 1'b0;
      step(1);
      if (coin_valid) begin
        nv++;
        chk("pulse_code", int'(coin_code), 1);
      end
    end
    chk("pulse_valid_cycles", nv, 1);
    chk("pulse_count", int'(coin_count), 0);

    // Bounce faster than the debounce window never produces an event.
    step(10);
    for (int i = 0; i < 30; i++) begin
      a = ~a;
      step(1);
      chk("bounce_valid", int'(coin_valid), 0);
    end
    a = 1'b0; step(10);
    chk("bounce_count", int'(coin_count), 0);

    // Six A coins with ready low: four queued, one pending, one dropped.
    rdy = 1'b0;
    repeat (6) begin a = 1'b1; step(8); a = 1'b0; step(8); end
    chk("ovf_count", int'(coin_count), 4);
    chk("ovf_flag", int'(overflow), 1);
    rdy = 1'b1; pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (coin_valid && rdy) pops++;
      step(1);
    end
    chk("ovf_pops", pops, 5);
    chk("ovf_drained", int'(coin_count), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Reset with three entries queued and B mid-debounce.
    rst = 1'b0; model_reset(); step(2); rst = 1'b1;
    rdy = 1'b0;
    repeat (3) begin a = 1'b1; step(8); a = 1'b0; step(8); end
    chk("pre_rst_count", int'(coin_count), 3);
    b = 1'b1; step(3);
    #2 rst = 1'b0; model_reset();
    #1 chk_idle("async_rst");
    b = 1'b0;
    @(posedge clk); step(2);
    rst = 1'b1;
    step(20);
    chk("post_rst_valid", int'(coin_valid), 0);
    chk("post_rst_count", int'(coin_count), 0);

    // Sensor held high through reset release counts as one coin.
    a = 1'b1; rst = 1'b0; model_reset(); step(2); rst = 1'b1;
    step(6);
    chk("held_not_yet", int'(coin_count), 0);
    step(1);
    chk("held_valid", int'(coin_valid), 1);
    chk("held_code", int'(coin_code), 1);
    a = 1'b0; rdy = 1'b1; step(12);
    chk("held_drained", int'(coin_count), 0);

    // Randomized run against the model; ready is starved in alternate windows.
    rst = 1'b0; model_reset(); step(2); rst = 1'b1;
    ra_left = 0; rb_left = 0;
    for (int i = 0; i < 3000; i++) begin
      chk("rnd_valid", int'(coin_valid), (q.size() > 0) ? 1 : 0);
      chk("rnd_code",  int'(coin_code),  (q.size() > 0) ? q[0] : 0);
      chk("rnd_count", int'(coin_count), q.size());
      chk("rnd_ovf",   int'(overflow),   int'(movf));
      chk("rnd_jam",   int'(jam),        0);
      if (ra_left == 0) begin a = ~a; ra_left = $urandom_range(1, 14); end
      if (rb_left == 0) begin b = ~b; rb_left = $urandom_range(1, 14); end
      ra_left--; rb_left--;
      if (((i / 300) % 2) == 1) rdy = ($urandom_range(0, 7) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      if (i == 1500) begin
        rst = 1'b0; model_reset(); step(2); rst = 1'b1;
      end
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
